law_vector_checker: RTL and testbench

LAW_VECTOR_CHECKER -- requirements
Module: law_vector_checker

---
 rtl/law_vector_checker.sv | 181 ++++++++++++++++++
 tb/tb_law_vector_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/law_vector_checker.sv
// law_vector_checker
//
// Walks a 3-input device under check through all eight input vectors
// (000..111), holds each vector for SETTLE cycles and then samples the
// two law-side results it returns. Mismatching vectors are counted and
// the first one is remembered.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   start        : begin a sweep (only honoured in IDLE)
//   abort        : cancel a running sweep (only honoured in DRIVE/SAMPLE)
//   lhs_in       : left-hand side of the law from the device under check
//   rhs_in       : right-hand side of the law from the device under check
//   a, b, c      : stimulus vector, a is the MSB
//   busy         : sweep in progress
//   done         : one-cycle pulse when a sweep completes
//   pass         : last completed sweep had no mismatches
//   mismatch_cnt : number of mismatching vectors (0..8)
//   fail_valid   : at least one mismatch recorded
//   first_fail   : index of the first mismatching vector
//
// state  | meaning
// IDLE   | waiting for start, results of the last sweep held
// DRIVE  | vector applied, waiting SETTLE cycles for the device to settle
// SAMPLE | vector still applied, lhs/rhs compared at the closing edge
// DONE   | one-cycle completion pulse, pass registered

module law_vector_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       lhs_in,
    input  logic       rhs_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [2:0] vec, vec_nxt;
    logic [3:0] settle, settle_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       pass_nxt;
    logic [3:0] mismatch_cnt_nxt;
    logic       fail_valid_nxt;
    logic [2:0] first_fail_nxt;
    logic       mismatch;
    logic [3:0] cnt_upd;

    assign mismatch = lhs_in ^ rhs_in;

    // The vector register drives the stimulus directly, so a/b/c are
    // register outputs and an abort returning vec to 0 also zeroes them.
    assign {a, b, c} = vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vec          <= 3'd0;
            settle       <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 4'd0;
            fail_valid   <= 1'b0;
            first_fail   <= 3'd0;
        end else begin
            state        <= state_nxt;
            vec          <= vec_nxt;
            settle       <= settle_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            mismatch_cnt <= mismatch_cnt_nxt;
            fail_valid   <= fail_valid_nxt;
            first_fail   <= first_fail_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        vec_nxt          = vec;
        settle_nxt       = settle;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        pass_nxt         = pass;
        mismatch_cnt_nxt = mismatch_cnt;
        fail_valid_nxt   = fail_valid;
        first_fail_nxt   = first_fail;
        cnt_upd          = mismatch_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt        = DRIVE;
                    vec_nxt          = 3'd0;
                    settle_nxt       = 4'd0;
                    busy_nxt         = 1'b1;
                    pass_nxt         = 1'b0;
                    mismatch_cnt_nxt = 4'd0;
                    fail_valid_nxt   = 1'b0;
                    first_fail_nxt   = 3'd0;
                end
            end

            DRIVE: begin
                if (abort) begin
                    state_nxt  = IDLE;
                    vec_nxt    = 3'd0;
                    settle_nxt = 4'd0;
                    busy_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                end else if (settle == SETTLE_LAST) begin
                    state_nxt  = SAMPLE;
                    settle_nxt = 4'd0;
                end else begin
                    settle_nxt = settle + 4'd1;
                end
            end

            SAMPLE: begin
                if (abort) begin
                    // abort wins over the compare: result registers untouched
                    state_nxt  = IDLE;
                    vec_nxt    = 3'd0;
                    settle_nxt = 4'd0;
                    busy_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                end else begin
                    if (mismatch) begin
                        cnt_upd          = mismatch_cnt + 4'd1;
                        mismatch_cnt_nxt = cnt_upd;
                        if (!fail_valid) begin
                            fail_valid_nxt = 1'b1;
                            first_fail_nxt = vec;
                        end
                    end
                    if (vec == 3'd7) begin
                        // vec holds at 7; pass uses the count including this vector
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (cnt_upd == 4'd0);
                    end else begin
                        state_nxt = DRIVE;
                        vec_nxt   = vec + 3'd1;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_law_vector_checker.sv
module tb_law_vector_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [1:0] abort_v = 2'b00;
    logic [1:0] lhs_v, rhs_v;
    logic [1:0] a_v, b_v, c_v, busy_v, done_v, pass_v, fv_v;
    logic [3:0] mm_v [2];
    logic [2:0] ff_v [2];
    int         mode [2] = '{0, 0};

    int n_ok  = 0;
    int n_tot = 0;

    always #5 clk = ~clk;

    // instance 0 uses SETTLE=1, instance 1 uses SETTLE=3
    law_vector_checker #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .lhs_in(lhs_v[0]), .rhs_in(rhs_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .mismatch_cnt(mm_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
    );

    law_vector_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .lhs_in(lhs_v[1]), .rhs_in(rhs_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .mismatch_cnt(mm_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
    );

    // Device under check: distributive law, optionally broken.
    // mode 0 correct, 1 rhs inverted at 101, 2 rhs = ~lhs, 3 rhs inverted at 001
    function automatic logic [1:0] dev(input int md, input logic [2:0] v);
        logic l, r;
        l = v[2] & (v[1] | v[0]);
        r = (v[2] & v[1]) | (v[2] & v[0]);
        case (md)
            1: if (v == 3'd5) r = ~r;
            2: r = ~l;
            3: if (v == 3'd1) r = ~r;
            default: ;
        endcase
        return {l, r};
    endfunction

    assign {lhs_v[0], rhs_v[0]} = dev(mode[0], {a_v[0], b_v[0], c_v[0]});
    assign {lhs_v[1], rhs_v[1]} = dev(mode[1], {a_v[1], b_v[1], c_v[1]});

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: tracks the sweep by elapsed cycles since the start edge.
    int cyc = 0;
    int m_act [2], m_t0 [2], m_mm [2], m_fv [2], m_ff [2];
    int m_pass [2], m_done [2], m_busy [2], m_abc [2], m_abck [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int s, j, v, was_done;
            s = (i == 0) ? 1 : 3;
            was_done = m_done[i];
            m_done[i] = 0;
            if (rst) begin
                m_act[i] = 0; m_busy[i] = 0; m_mm[i] = 0; m_fv[i] = 0;
                m_ff[i] = 0; m_pass[i] = 0; m_abc[i] = 0; m_abck[i] = 1;
            end else if (m_act[i] != 0) begin
                j = cyc - m_t0[i] - 1;
                v = j / (s + 1);
                if (abort_v[i]) begin
                    m_act[i] = 0; m_busy[i] = 0; m_abc[i] = 0;
                    m_abck[i] = 1; m_pass[i] = 0;
                end else if (j % (s + 1) == s) begin
                    if (^dev(mode[i], 3'(v))) begin
                        m_mm[i]++;
                        if (m_fv[i] == 0) begin
                            m_fv[i] = 1;
                            m_ff[i] = v;
                        end
                    end
                    if (v == 7) begin
                        m_act[i] = 0; m_busy[i] = 0; m_done[i] = 1;
                        m_pass[i] = (m_mm[i] == 0) ? 1 : 0;
                        m_abck[i] = 0;
                    end else begin
                        m_abc[i] = v + 1;
                    end
                end
            end else if (was_done == 0 && start_v[i]) begin
                m_act[i] = 1; m_t0[i] = cyc; m_busy[i] = 1; m_mm[i] = 0;
                m_fv[i] = 0; m_ff[i] = 0; m_pass[i] = 0; m_abc[i] = 0;
                m_abck[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d busy", i), int'(busy_v[i]), m_busy[i]);
            chk($sformatf("u%0d done", i), int'(done_v[i]), m_done[i]);
            chk($sformatf("u%0d pass", i), int'(pass_v[i]), m_pass[i]);
            chk($sformatf("u%0d mismatch_cnt", i), int'(mm_v[i]), m_mm[i]);
            chk($sformatf("u%0d fail_valid", i), int'(fv_v[i]), m_fv[i]);
            chk($sformatf("u%0d first_fail", i), int'(ff_v[i]), m_ff[i]);
            if (m_abck[i] != 0)
                chk($sformatf("u%0d abc", i), int'({a_v[i], b_v[i], c_v[i]}), m_abc[i]);
        end
    end

    // called at a negedge: start sampled at the next edge, returns in cycle 0
    task automatic launch(input int i);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // returns edge offset from the start edge at which done is seen, -1 on timeout
    task automatic wait_done(input int i, input int off, output int lat);
        lat = -1;
        for (int n = off + 1; n <= off + 200; n++) begin
            @(negedge clk);
            if (done_v[i]) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;
    int ndone;

    initial begin
        repeat (3) @(negedge clk);

        // A: correct law, start on the first edge after reset release
        mode[0] = 0;
        rst = 1'b0;
        launch(0);
        wait_done(0, 0, lat);
        chk("A done edge", lat, 16);
        @(negedge clk);
        chk("A pass", int'(pass_v[0]), 1);
        chk("A mismatch_cnt", int'(mm_v[0]), 0);
        chk("A fail_valid", int'(fv_v[0]), 0);

        // B: rhs broken only at 101
        mode[0] = 1;
        launch(0);
        wait_done(0, 0, lat);
        chk("B done edge", lat, 16);
        @(negedge clk);
        chk("B mismatch_cnt", int'(mm_v[0]), 1);
        chk("B first_fail", int'(ff_v[0]), 5);
        chk("B fail_valid", int'(fv_v[0]), 1);
        chk("B pass", int'(pass_v[0]), 0);

        // C: rhs always inverted, SETTLE=3
        mode[1] = 2;
        launch(1);
        wait_done(1, 0, lat);
        chk("C done edge", lat, 32);
        @(negedge clk);
        chk("C mismatch_cnt", int'(mm_v[1]), 8);
        chk("C first_fail", int'(ff_v[1]), 0);
        chk("C pass", int'(pass_v[1]), 0);

        // D: start re-pulsed at vector 3 and during DONE
        mode[0] = 1;
        launch(0);
        repeat (6) @(negedge clk);
        chk("D abc at v3", int'({a_v[0], b_v[0], c_v[0]}), 3);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 7, lat);
        chk("D done edge", lat, 16);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("D busy after DONE start", int'(busy_v[0]), 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("D extra done", ndone, 0);
        chk("D mismatch_cnt", int'(mm_v[0]), 1);
        chk("D first_fail", int'(ff_v[0]), 5);

        // E: reset during vector 4 SAMPLE, then a fresh sweep
        mode[0] = 3;
        launch(0);
        repeat (9) @(negedge clk);
        chk("E abc at v4", int'({a_v[0], b_v[0], c_v[0]}), 4);
        chk("E fail_valid before rst", int'(fv_v[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("E busy", int'(busy_v[0]), 0);
        chk("E done", int'(done_v[0]), 0);
        chk("E abc", int'({a_v[0], b_v[0], c_v[0]}), 0);
        chk("E mismatch_cnt", int'(mm_v[0]), 0);
        chk("E fail_valid", int'(fv_v[0]), 0);
        chk("E first_fail", int'(ff_v[0]), 0);
        mode[0] = 0;
        launch(0);
        chk("E restart busy", int'(busy_v[0]), 1);
        chk("E restart abc", int'({a_v[0], b_v[0], c_v[0]}), 0);
        wait_done(0, 0, lat);
        chk("E done edge", lat, 16);
        @(negedge clk);
        chk("E pass", int'(pass_v[0]), 1);

        // F: abort during vector 2 after a mismatch at vector 1
        mode[0] = 3;
        launch(0);
        repeat (4) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("F busy", int'(busy_v[0]), 0);
        chk("F abc", int'({a_v[0], b_v[0], c_v[0]}), 0);
        chk("F done", int'(done_v[0]), 0);
        chk("F mismatch_cnt", int'(mm_v[0]), 1);
        chk("F first_fail", int'(ff_v[0]), 1);
        chk("F pass", int'(pass_v[0]), 0);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("F done after abort", ndone, 0);
        chk("F mismatch_cnt held", int'(mm_v[0]), 1);

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
